// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the spi_master_mc family.
package spi_pkg;

  // Transfer sequencing: idle, CS setup, data phase, CS hold.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Per-transfer mode, captured when a transfer is accepted.
  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_cfg_t;

  // System clocks per SCLK half period.
  function automatic int half_of(input int clk_div);
    return clk_div / 2;
  endfunction

  // Width of the chip-select index; never narrower than one bit.
  function automatic int csw_of(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_w_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_mc_clk_gen.sv
// Half-period tick generator for the SPI master. While enabled it pulses
// tick_o once every HALF system clocks and reports whether that tick is a
// leading (away from idle) or trailing SCLK edge. Disabling it parks the
// counter and phase, so every enable rise starts a fresh period.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic srst_i,
  input  logic en_i,
  output logic tick_o,
  output logic lead_o
);

  localparam int HALF = half_of(CLK_DIV);
  localparam int CW   = cnt_w_of(HALF);
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lead_q, lead_d;

  // Next half-period count and edge phase; both park while disabled.
  always_comb begin
    cnt_d  = cnt_q;
    lead_d = lead_q;
    if (!en_i) begin
      cnt_d  = '0;
      lead_d = 1'b1;
    end else if (cnt_q == LAST) begin
      cnt_d  = '0;
      lead_d = ~lead_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter and phase registers.
  always_ff @(posedge clk) begin
    if (srst_i) begin
      cnt_q  <= '0;
      lead_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      lead_q <= lead_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);
  assign lead_o = lead_q;

endmodule

// File: rtl/spi_master_mc.sv
// Parametrised SPI master with per-transfer CPOL/CPHA and bit order.
// A transfer is SETUP (one half period, CS low, first bit on MOSI), then
// 2*DATA_BITS SCLK edges in XFER, then HOLD (one half period) before CS
// releases and done pulses together with the rx_data update.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int CLK_DIV   = 8,
  parameter int DATA_BITS = 8,
  parameter int NUM_CS    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [csw_of(NUM_CS)-1:0]   cs_sel,
  input  logic                        cpol,
  input  logic                        cpha,
  input  logic                        lsb_first,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic                        busy,
  output logic                        done,
  output logic                        sclk,
  output logic                        mosi,
  input  logic                        miso,
  output logic [NUM_CS-1:0]           cs_n
);

  localparam int CSW = csw_of(NUM_CS);
  localparam int BW  = cnt_w_of(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  state_t                 state_q, state_d;
  spi_cfg_t               cfg_q, cfg_d;
  logic [DATA_BITS-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_BITS-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   sclk_q, sclk_d;
  logic                   mosi_q, mosi_d;
  logic [NUM_CS-1:0]      cs_n_q, cs_n_d;

  logic                   tick;
  logic                   lead;
  logic                   last_lead;
  logic                   edge_ev;
  logic                   lead_edge;
  logic                   trail_edge;
  logic                   do_shift;
  logic                   do_sample;
  logic [NUM_CS-1:0]      cs_hit;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk    (clk),
    .srst_i (reset),
    .en_i   (state_q != IDLE),
    .tick_o (tick),
    .lead_o (lead)
  );

  // One-hot select decode; an out-of-range index matches no line.
  for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
    assign cs_hit[gi] = (cs_sel == CSW'(gi));
  end

  // Edge bookkeeping. The SETUP-ending tick is the first leading edge; the
  // leading-phase tick seen with the bit counter at its last value closes
  // XFER instead of producing a seventeenth edge.
  always_comb begin
    last_lead  = (state_q == XFER) && tick && lead && (bit_cnt_q == LAST_BIT);
    edge_ev    = tick && ((state_q == SETUP) || ((state_q == XFER) && !last_lead));
    lead_edge  = edge_ev && lead;
    trail_edge = edge_ev && !lead;
    do_sample  = cfg_q.cpha ? trail_edge : lead_edge;
    // CPHA=1 skips the very first leading edge (it re-drives bit 0);
    // CPHA=0 skips the final trailing edge (no bit left to present).
    do_shift   = cfg_q.cpha ? (lead_edge && (state_q == XFER))
                            : (trail_edge && (bit_cnt_q != LAST_BIT));
  end

  // Next-state and datapath next values; defaults hold every register.
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;

    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        cs_n_d = '1;
        busy_d = 1'b0;
        if (start) begin
          cfg_d.cpol      = cpol;
          cfg_d.cpha      = cpha;
          cfg_d.lsb_first = lsb_first;
          tx_sh_d         = tx_data;
          rx_sh_d         = '0;
          bit_cnt_d       = '0;
          mosi_d          = lsb_first ? tx_data[0] : tx_data[DATA_BITS-1];
          cs_n_d          = ~cs_hit;
          busy_d          = 1'b1;
          state_d         = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (last_lead) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        sclk_d = cfg_q.cpol;
        if (tick) begin
          state_d   = IDLE;
          cs_n_d    = '1;
          rx_data_d = rx_sh_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (edge_ev) begin
      sclk_d = ~sclk_q;
    end

    if (do_shift) begin
      if (cfg_q.lsb_first) begin
        tx_sh_d = tx_sh_q >> 1;
        mosi_d  = tx_sh_q[1];
      end else begin
        tx_sh_d = tx_sh_q << 1;
        mosi_d  = tx_sh_q[DATA_BITS-2];
      end
    end

    if (do_sample) begin
      rx_sh_d = cfg_q.lsb_first ? {miso, rx_sh_q[DATA_BITS-1:1]}
                                : {rx_sh_q[DATA_BITS-2:0], miso};
    end

    // Bit index advances on each leading-phase tick after the first bit and
    // saturates at the last bit.
    if ((state_q == XFER) && tick && lead && (bit_cnt_q != LAST_BIT)) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
    end else begin
      cfg_q     <= cfg_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: a four-select build and a three-select
// build share all inputs; a behavioural slave inside run_xfer follows SCLK.
module tb_spi_master_mc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cs_sel = 2'd0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       lsb_first = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso = 1'b0;

  logic [7:0] rx_data, rx_data3;
  logic       busy, done, sclk, mosi;
  logic       busy3, done3, sclk3, mosi3;
  logic [3:0] cs_n;
  logic [2:0] cs_n3;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] rx3;
    logic [7:0] seq;
    int         edges;
    int         busy_cyc;
    int         dones;
    int         dones3;
    logic [3:0] cs_mask;
    logic [2:0] cs3_mask;
    logic       idle_sclk;
    logic       end_sclk;
  } xfer_res_t;

  always #5 clk = ~clk;

  spi_master_mc #(.CLK_DIV(8), .DATA_BITS(8), .NUM_CS(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .cs_sel(cs_sel), .cpol(cpol),
    .cpha(cpha), .lsb_first(lsb_first), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_master_mc #(.CLK_DIV(8), .DATA_BITS(8), .NUM_CS(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .cs_sel(cs_sel), .cpol(cpol),
    .cpha(cpha), .lsb_first(lsb_first), .tx_data(tx_data), .rx_data(rx_data3),
    .busy(busy3), .done(done3), .sclk(sclk3), .mosi(mosi3), .miso(miso), .cs_n(cs_n3)
  );

  function automatic logic sbit(input logic [7:0] w, input int k, input logic lsb);
    return lsb ? w[k] : w[7-k];
  endfunction

  // Runs one transfer from a negedge. The slave sends sw in the chosen bit
  // order, changing MISO only on its own shift edge, and records MOSI bits in
  // arrival order. quick: start immediately (back-to-back); chain: return on
  // the done cycle; poke: cycle at which a spurious start with altered inputs
  // is pulsed (negative for none).
  task automatic run_xfer(input logic [1:0] cs, input logic pol, input logic pha,
                          input logic lsb, input logic [7:0] tx, input logic [7:0] sw,
                          input bit quick, input bit chain, input int poke,
                          output xfer_res_t r);
    int   idx;
    int   done_at;
    logic prev;
    r.rx = 8'h00; r.rx3 = 8'h00; r.seq = 8'h00; r.edges = 0; r.busy_cyc = 0;
    r.dones = 0; r.dones3 = 0; r.cs_mask = 4'h0; r.cs3_mask = 3'h0;
    cpol = pol; cpha = pha; lsb_first = lsb; cs_sel = cs; tx_data = tx;
    if (!quick) begin
      start = 1'b0;
      @(negedge clk);
    end
    r.idle_sclk = sclk;
    start = 1'b1;
    miso = pha ? ~sbit(sw, 0, lsb) : sbit(sw, 0, lsb);
    prev = sclk;
    idx = 0;
    done_at = -1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (c == poke) begin
        start = 1'b1; tx_data = ~tx; cpol = ~pol; cpha = ~pha; cs_sel = cs + 2'd1;
      end else if (c == poke + 1) begin
        start = 1'b0; tx_data = tx; cpol = pol; cpha = pha; cs_sel = cs;
      end
      if (busy) r.busy_cyc++;
      if (done) begin r.dones++; r.rx = rx_data; if (done_at < 0) done_at = c; end
      if (done3) begin r.dones3++; r.rx3 = rx_data3; end
      r.cs_mask  = r.cs_mask | ~cs_n;
      r.cs3_mask = r.cs3_mask | ~cs_n3;
      if (sclk !== prev) begin
        r.edges++;
        prev = sclk;
        if (sclk != pol) begin
          if (!pha) r.seq = {r.seq[6:0], mosi};
          else if (idx < 8) miso = sbit(sw, idx, lsb);
        end else begin
          if (!pha) begin
            idx++;
            if (idx < 8) miso = sbit(sw, idx, lsb);
          end else begin
            r.seq = {r.seq[6:0], mosi};
            idx++;
          end
        end
      end
      if (done_at >= 0 && (chain || c >= done_at + 4)) break;
    end
    r.end_sclk = sclk;
    n_vec++;
    if (r.dones == 0) begin
      n_err++;
      $display("FAIL xfer_timeout: got no done within 150 cycles, expected a done pulse (tx=%h)", tx);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (sclk !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    n_vec++; if (mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    n_vec++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_rx: got %h expected 00", rx_data); end
    n_vec++; if (cs_n !== 4'hF) begin n_err++; $display("FAIL reset_cs_n: got %h expected f", cs_n); end
    n_vec++; if (cs_n3 !== 3'h7) begin n_err++; $display("FAIL reset_cs_n3: got %h expected 7", cs_n3); end
    reset = 1'b0;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_mode0();
    xfer_res_t r;
    run_xfer(2'd0, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h77, 1'b0, 1'b0, -1, r);
    n_vec++; if (r.rx !== 8'h77) begin n_err++; $display("FAIL mode0_rx: got %h expected 77", r.rx); end
    n_vec++; if (r.seq !== 8'hA5) begin n_err++; $display("FAIL mode0_mosi_seq: got %b expected 10100101", r.seq); end
    n_vec++; if (r.cs_mask !== 4'b0001) begin n_err++; $display("FAIL mode0_cs: got %b expected 0001", r.cs_mask); end
    n_vec++; if (r.busy_cyc != 72) begin n_err++; $display("FAIL mode0_busy_len: got %0d expected 72", r.busy_cyc); end
    n_vec++; if (r.dones != 1) begin n_err++; $display("FAIL mode0_done_count: got %0d expected 1", r.dones); end
    n_vec++; if (r.edges != 16) begin n_err++; $display("FAIL mode0_edges: got %0d expected 16", r.edges); end
    n_vec++; if (cs_n !== 4'hF) begin n_err++; $display("FAIL mode0_cs_release: got %h expected f", cs_n); end
    $display("test_mode0: rx=%h seq=%h busy=%0d", r.rx, r.seq, r.busy_cyc);
  endtask

  task automatic test_modes();
    xfer_res_t r;
    for (int m = 0; m < 4; m++) begin
      logic pol, pha;
      pol = (m >= 2);
      pha = (m % 2 == 1);
      run_xfer(2'd1, pol, pha, 1'b0, 8'hA1, 8'h76, 1'b0, 1'b0, -1, r);
      n_vec++; if (r.idle_sclk !== pol) begin n_err++; $display("FAIL mode%0d_idle_sclk: got %b expected %b", m, r.idle_sclk, pol); end
      n_vec++; if (r.end_sclk !== pol) begin n_err++; $display("FAIL mode%0d_end_sclk: got %b expected %b", m, r.end_sclk, pol); end
      n_vec++; if (r.rx !== 8'h76) begin n_err++; $display("FAIL mode%0d_rx: got %h expected 76", m, r.rx); end
      n_vec++; if (r.seq !== 8'hA1) begin n_err++; $display("FAIL mode%0d_mosi_seq: got %h expected a1", m, r.seq); end
      n_vec++; if (r.edges != 16) begin n_err++; $display("FAIL mode%0d_edges: got %0d expected 16", m, r.edges); end
      $display("test_modes: mode=%0d rx=%h seq=%h", m, r.rx, r.seq);
    end
  endtask

  task automatic test_lsb_first();
    xfer_res_t r;
    run_xfer(2'd0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h80, 1'b0, 1'b0, -1, r);
    n_vec++; if (r.seq !== 8'b1000_0000) begin n_err++; $display("FAIL lsb_mosi_seq: got %b expected 10000000", r.seq); end
    n_vec++; if (r.rx !== 8'h80) begin n_err++; $display("FAIL lsb_rx: got %h expected 80", r.rx); end
    $display("test_lsb_first: rx=%h seq=%b", r.rx, r.seq);
  endtask

  task automatic test_back_to_back();
    xfer_res_t r1, r2;
    run_xfer(2'd0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h99, 1'b0, 1'b1, -1, r1);
    n_vec++; if (r1.rx !== 8'h99) begin n_err++; $display("FAIL b2b_first_rx: got %h expected 99", r1.rx); end
    run_xfer(2'd0, 1'b0, 1'b0, 1'b0, 8'hA3, 8'h46, 1'b1, 1'b0, 30, r2);
    n_vec++; if (r2.rx !== 8'h46) begin n_err++; $display("FAIL b2b_second_rx: got %h expected 46", r2.rx); end
    n_vec++; if (r2.seq !== 8'hA3) begin n_err++; $display("FAIL b2b_second_seq: got %h expected a3", r2.seq); end
    n_vec++; if (r2.dones != 1) begin n_err++; $display("FAIL b2b_done_count: got %0d expected 1", r2.dones); end
    n_vec++; if (r2.busy_cyc != 72) begin n_err++; $display("FAIL b2b_busy_len: got %0d expected 72", r2.busy_cyc); end
    $display("test_back_to_back: rx1=%h rx2=%h dones=%0d", r1.rx, r2.rx, r2.dones);
  endtask

  task automatic test_reset_mid();
    xfer_res_t r;
    int dcount;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; cs_sel = 2'd0; tx_data = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (36) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_vec++; if (cs_n !== 4'hF) begin n_err++; $display("FAIL rstmid_cs_n: got %h expected f", cs_n); end
    n_vec++; if (sclk !== 1'b0) begin n_err++; $display("FAIL rstmid_sclk: got %b expected 0", sclk); end
    dcount = (done === 1'b1) ? 1 : 0;
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    n_vec++; if (dcount != 0) begin n_err++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", dcount); end
    run_xfer(2'd0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hC3, 1'b0, 1'b0, -1, r);
    n_vec++; if (r.rx !== 8'hC3) begin n_err++; $display("FAIL rstmid_after_rx: got %h expected c3", r.rx); end
    n_vec++; if (r.seq !== 8'h3C) begin n_err++; $display("FAIL rstmid_after_seq: got %h expected 3c", r.seq); end
    $display("test_reset_mid: rx=%h seq=%h", r.rx, r.seq);
  endtask

  task automatic test_cs_select();
    xfer_res_t r;
    run_xfer(2'd3, 1'b0, 1'b0, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0, -1, r);
    n_vec++; if (r.cs_mask !== 4'b1000) begin n_err++; $display("FAIL cs3_mask: got %b expected 1000", r.cs_mask); end
    n_vec++; if (r.cs3_mask !== 3'b000) begin n_err++; $display("FAIL ncs3_mask: got %b expected 000", r.cs3_mask); end
    n_vec++; if (r.dones3 != 1) begin n_err++; $display("FAIL ncs3_done: got %0d expected 1", r.dones3); end
    n_vec++; if (r.rx3 !== 8'h22) begin n_err++; $display("FAIL ncs3_rx: got %h expected 22", r.rx3); end
    $display("test_cs_select: cs_sel=3 mask=%b mask3=%b", r.cs_mask, r.cs3_mask);
    run_xfer(2'd2, 1'b0, 1'b0, 1'b0, 8'h33, 8'h44, 1'b0, 1'b0, -1, r);
    n_vec++; if (r.cs_mask !== 4'b0100) begin n_err++; $display("FAIL cs2_mask: got %b expected 0100", r.cs_mask); end
    n_vec++; if (r.cs3_mask !== 3'b100) begin n_err++; $display("FAIL ncs3_sel2_mask: got %b expected 100", r.cs3_mask); end
    n_vec++; if (r.rx !== 8'h44) begin n_err++; $display("FAIL cs2_rx: got %h expected 44", r.rx); end
    $display("test_cs_select: cs_sel=2 mask=%b mask3=%b", r.cs_mask, r.cs3_mask);
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_modes();
    test_lsb_first();
    test_back_to_back();
    test_reset_mid();
    test_cs_select();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
